// File: rtl/engine_set_ops_configure_request_generator_pkg.sv
// Shared types for the set-ops configuration request generator.
// Memory packets, FIFO status bundles and the request FSM encoding.
package engine_set_ops_configure_request_generator_pkg;

  localparam int M_AXI_MEMORY_ADDR_WIDTH = 32;
  localparam int M_AXI_MEMORY_DATA_WIDTH = 32;
  localparam int ID_W = 8;

  typedef logic [M_AXI_MEMORY_ADDR_WIDTH-1:0] type_memory_address;
  typedef logic [M_AXI_MEMORY_ADDR_WIDTH-1:0] type_memory_response_offset;

  typedef enum logic [1:0] {
    CMD_INVALID,
    CMD_MEM_READ,
    CMD_MEM_WRITE,
    CMD_MEM_CONFIGURE
  } type_memory_cmd;

  typedef struct packed {
    logic [ID_W-1:0] id_cu;
    logic [ID_W-1:0] id_bundle;
    logic [ID_W-1:0] id_lane;
    logic [ID_W-1:0] id_engine;
    logic [ID_W-1:0] id_module;
  } MemoryPacketRoute;

  typedef struct packed {
    type_memory_address         base;
    type_memory_response_offset offset;
  } MemoryPacketAddress;

  typedef struct packed {
    MemoryPacketRoute   route;
    MemoryPacketAddress address;
  } MemoryPacketMeta;

  typedef struct packed {
    type_memory_cmd  cmd;
    MemoryPacketMeta meta;
  } MemoryPacketRequestPayload;

  typedef struct packed {
    logic                      valid;
    MemoryPacketRequestPayload payload;
  } MemoryPacketRequest;

  typedef struct packed {
    MemoryPacketMeta                    meta;
    logic [M_AXI_MEMORY_DATA_WIDTH-1:0] data;
  } MemoryPacketResponsePayload;

  typedef struct packed {
    logic                       valid;
    MemoryPacketResponsePayload payload;
  } MemoryPacketResponse;

  typedef struct packed {
    logic rd_en;
  } FIFOStateSignalsInput;

  typedef struct packed {
    logic full;
    logic empty;
    logic valid;
    logic prog_full;
    logic wr_rst_busy;
    logic rd_rst_busy;
  } FIFOStateSignalsOutput;

  typedef enum logic [2:0] {
    CFG_IDLE,
    CFG_SETUP,
    CFG_READY,
    CFG_ISSUE,
    CFG_WAIT_RESP,
    CFG_DONE
  } type_config_request_state;

endpackage

// File: rtl/xpm_fifo_sync_wrapper.sv
// Synchronous request FIFO with registered read data and valid flag.
// Reset-busy flags stay high for a few cycles after srst releases.
module xpm_fifo_sync_wrapper #(
  parameter int FIFO_WRITE_DEPTH = 16,
  parameter int WRITE_DATA_WIDTH = 32,
  parameter int PROG_FULL_THRESH = 8
) (
  input  logic                        clk,
  input  logic                        srst,
  input  logic [WRITE_DATA_WIDTH-1:0] din,
  input  logic                        wr_en,
  input  logic                        rd_en,
  output logic [WRITE_DATA_WIDTH-1:0] dout,
  output logic                        full,
  output logic                        empty,
  output logic                        valid,
  output logic                        prog_full,
  output logic                        wr_rst_busy,
  output logic                        rd_rst_busy
);

  localparam int AW = $clog2(FIFO_WRITE_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_WRITE_DEPTH);
  localparam logic [AW:0] THRESH_C = (AW+1)'(PROG_FULL_THRESH);

  logic [WRITE_DATA_WIDTH-1:0] mem [FIFO_WRITE_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [1:0]    busy_cnt;
  logic          busy;
  logic          do_wr;
  logic          do_rd;

  assign busy        = (busy_cnt != 2'd0);
  assign wr_rst_busy = busy;
  assign rd_rst_busy = busy;
  assign empty       = (count == '0);
  assign full        = (count == DEPTH_C) | busy;
  assign prog_full   = (count >= THRESH_C) | busy;
  assign do_wr       = wr_en & ~full;
  assign do_rd       = rd_en & ~empty & ~busy;

  always_ff @(posedge clk) begin
    if (srst) begin
      busy_cnt <= 2'd3;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      valid    <= 1'b0;
    end else begin
      if (busy) busy_cnt <= busy_cnt - 2'd1;
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      valid <= do_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
    if (do_rd) dout <= mem[rd_ptr];
  end

endmodule

// File: rtl/engine_set_ops_configure_request_generator.sv
// Issues one engine's configuration reads into a request FIFO and
// counts the in-range responses that come back to flag completion.
module engine_set_ops_configure_request_generator
  import engine_set_ops_configure_request_generator_pkg::*;
#(
  parameter int ID_CU            = 0,
  parameter int ID_BUNDLE        = 0,
  parameter int ID_LANE          = 0,
  parameter int ID_ENGINE        = 0,
  parameter int ID_RELATIVE      = 0,
  parameter int ID_MODULE        = 0,
  parameter int FIFO_WRITE_DEPTH = 16,
  parameter int PROG_THRESH      = 8,
  parameter int ENGINE_SEQ_WIDTH = 16,
  parameter int ENGINE_SEQ_MIN   = ID_RELATIVE*ENGINE_SEQ_WIDTH,
  parameter int ENGINE_SEQ_MAX   = ENGINE_SEQ_MIN+ENGINE_SEQ_WIDTH
) (
  input  logic                  ap_clk,
  input  logic                  areset,
  input  logic                  start_in,
  input  type_memory_address    base_address_in,
  input  MemoryPacketResponse   response_memory_in,
  output MemoryPacketRequest    request_memory_out,
  input  FIFOStateSignalsInput  fifo_request_memory_out_signals_in,
  output FIFOStateSignalsOutput fifo_request_memory_out_signals_out,
  output logic                  fifo_setup_signal,
  output logic                  done_out
);

  localparam int CNT_W = $clog2(ENGINE_SEQ_WIDTH)+1;
  localparam int OFF_W = $bits(type_memory_response_offset);
  localparam int REQ_W = $bits(MemoryPacketRequestPayload);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(ENGINE_SEQ_WIDTH-1);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(ENGINE_SEQ_WIDTH);
  localparam type_memory_response_offset MIN_C = OFF_W'(ENGINE_SEQ_MIN);
  localparam type_memory_response_offset SPAN_C =
    OFF_W'(ENGINE_SEQ_MAX-ENGINE_SEQ_MIN);

  logic areset_r;
  logic start_r;
  logic resp_valid_r;
  logic rd_en_r;
  MemoryPacketResponsePayload resp_r;
  type_memory_address base_in_r;
  type_memory_address base_r;

  type_config_request_state state;
  type_config_request_state state_n;
  logic [CNT_W-1:0] issue_count;
  logic [CNT_W-1:0] issue_count_n;
  logic [CNT_W-1:0] resp_count;
  logic [CNT_W-1:0] resp_count_n;
  logic load_base;
  logic counting;

  type_memory_response_offset resp_rel;
  logic resp_hit;
  logic fifo_wr_en;
  logic fifo_rd_en;
  logic fifo_busy;
  MemoryPacketRequestPayload req_din;
  MemoryPacketRequestPayload req_dout;
  FIFOStateSignalsOutput fifo_raw;
  logic unused_resp;

  always_ff @(posedge ap_clk) begin
    areset_r <= areset;
    if (areset_r) begin
      start_r      <= 1'b0;
      resp_valid_r <= 1'b0;
      rd_en_r      <= 1'b0;
    end else begin
      start_r      <= start_in;
      resp_valid_r <= response_memory_in.valid;
      rd_en_r      <= fifo_request_memory_out_signals_in.rd_en;
    end
  end

  always_ff @(posedge ap_clk) begin
    resp_r     <= response_memory_in.payload;
    base_in_r  <= base_address_in;
    if (load_base) base_r <= base_in_r;
  end

  // Unsigned distance from the first offset folds both range bounds
  assign resp_rel = resp_r.meta.address.offset - MIN_C;
  assign resp_hit = resp_valid_r & (resp_rel < SPAN_C);
  assign counting = (state == CFG_ISSUE) | (state == CFG_WAIT_RESP);
  assign unused_resp = ^{resp_r.data, resp_r.meta.route,
                         resp_r.meta.address.base};

  always_comb begin
    state_n       = state;
    issue_count_n = issue_count;
    resp_count_n  = resp_count;
    fifo_wr_en    = 1'b0;
    load_base     = 1'b0;
    if (counting && resp_hit && resp_count != FULL_C)
      resp_count_n = resp_count + CNT_W'(1);
    unique case (state)
      CFG_IDLE: state_n = CFG_SETUP;
      CFG_SETUP: begin
        if (~fifo_raw.wr_rst_busy & ~fifo_raw.rd_rst_busy)
          state_n = CFG_READY;
      end
      CFG_READY, CFG_DONE: begin
        if (start_r) begin
          state_n       = CFG_ISSUE;
          issue_count_n = '0;
          resp_count_n  = '0;
          load_base     = 1'b1;
        end
      end
      CFG_ISSUE: begin
        if (~fifo_raw.prog_full) begin
          fifo_wr_en    = 1'b1;
          issue_count_n = issue_count + CNT_W'(1);
          if (issue_count == LAST_C) state_n = CFG_WAIT_RESP;
        end
      end
      CFG_WAIT_RESP: begin
        if (resp_count_n == FULL_C) state_n = CFG_DONE;
      end
      default: state_n = CFG_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (areset_r) begin
      state       <= CFG_IDLE;
      issue_count <= '0;
      resp_count  <= '0;
    end else begin
      state       <= state_n;
      issue_count <= issue_count_n;
      resp_count  <= resp_count_n;
    end
  end

  assign done_out = (state == CFG_DONE);

  always_comb begin
    req_din                      = '0;
    req_din.cmd                  = CMD_MEM_READ;
    req_din.meta.route.id_cu     = ID_W'(ID_CU);
    req_din.meta.route.id_bundle = ID_W'(ID_BUNDLE);
    req_din.meta.route.id_lane   = ID_W'(ID_LANE);
    req_din.meta.route.id_engine = ID_W'(ID_ENGINE);
    req_din.meta.route.id_module = ID_W'(ID_MODULE);
    req_din.meta.address.base    = base_r;
    req_din.meta.address.offset  = MIN_C + OFF_W'(issue_count);
  end

  assign fifo_rd_en = ~fifo_raw.empty & rd_en_r;
  assign fifo_busy  = fifo_raw.wr_rst_busy | fifo_raw.rd_rst_busy;

  xpm_fifo_sync_wrapper #(
    .FIFO_WRITE_DEPTH (FIFO_WRITE_DEPTH),
    .WRITE_DATA_WIDTH (REQ_W),
    .PROG_FULL_THRESH (PROG_THRESH)
  ) u_request_fifo (
    .clk         (ap_clk),
    .srst        (areset_r),
    .din         (req_din),
    .wr_en       (fifo_wr_en),
    .rd_en       (fifo_rd_en),
    .dout        (req_dout),
    .full        (fifo_raw.full),
    .empty       (fifo_raw.empty),
    .valid       (fifo_raw.valid),
    .prog_full   (fifo_raw.prog_full),
    .wr_rst_busy (fifo_raw.wr_rst_busy),
    .rd_rst_busy (fifo_raw.rd_rst_busy)
  );

  always_ff @(posedge ap_clk) begin
    if (areset_r) begin
      request_memory_out.valid <= 1'b0;
      fifo_setup_signal        <= 1'b1;
    end else begin
      request_memory_out.valid <= fifo_raw.valid;
      fifo_setup_signal        <= fifo_busy;
    end
    request_memory_out.payload          <= req_dout;
    fifo_request_memory_out_signals_out <= fifo_raw;
  end

endmodule

// File: tb/tb_engine_set_ops_configure_request_generator.sv
// Directed bench for the configuration request generator.
// Engine index 1 so valid offsets are 16..31.
module tb_engine_set_ops_configure_request_generator;
  import engine_set_ops_configure_request_generator_pkg::*;

  logic ap_clk = 1'b0;
  logic areset;
  logic start_in;
  type_memory_address base_address_in;
  MemoryPacketResponse response_memory_in;
  MemoryPacketRequest request_memory_out;
  FIFOStateSignalsInput fifo_in;
  FIFOStateSignalsOutput fifo_out;
  logic fifo_setup_signal;
  logic done_out;

  int vectors = 0;
  int errors = 0;
  MemoryPacketRequestPayload q[$];

  always #5 ap_clk = ~ap_clk;

  engine_set_ops_configure_request_generator #(
    .ID_CU       (2),
    .ID_BUNDLE   (1),
    .ID_LANE     (3),
    .ID_ENGINE   (4),
    .ID_RELATIVE (1),
    .ID_MODULE   (5)
  ) dut (
    .ap_clk                              (ap_clk),
    .areset                              (areset),
    .start_in                            (start_in),
    .base_address_in                     (base_address_in),
    .response_memory_in                  (response_memory_in),
    .request_memory_out                  (request_memory_out),
    .fifo_request_memory_out_signals_in  (fifo_in),
    .fifo_request_memory_out_signals_out (fifo_out),
    .fifo_setup_signal                   (fifo_setup_signal),
    .done_out                            (done_out)
  );

  always @(negedge ap_clk)
    if (request_memory_out.valid === 1'b1)
      q.push_back(request_memory_out.payload);

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge ap_clk);
  endtask

  task automatic pulse_start(input logic [31:0] base);
    @(negedge ap_clk);
    base_address_in = base;
    start_in = 1'b1;
    @(negedge ap_clk);
    start_in = 1'b0;
  endtask

  task automatic wait_reqs(input int n, input int budget);
    int t = 0;
    while (q.size() < n && t < budget) begin
      @(negedge ap_clk);
      t++;
    end
  endtask

  task automatic wait_setup(input string tag);
    int t = 0;
    while (fifo_setup_signal !== 1'b0 && t < 40) begin
      @(negedge ap_clk);
      t++;
    end
    chk({tag, "_setup_rel"}, 64'(fifo_setup_signal), 64'd0);
  endtask

  task automatic check_burst(input string tag, input logic [31:0] base);
    chk({tag, "_count"}, 64'(q.size()), 64'd16);
    for (int i = 0; i < q.size() && i < 16; i++) begin
      chk({tag, "_off"}, 64'(q[i].meta.address.offset), 64'(16 + i));
      chk({tag, "_base"}, 64'(q[i].meta.address.base), 64'(base));
      chk({tag, "_cmd"}, 64'(q[i].cmd), 64'(CMD_MEM_READ));
    end
  endtask

  task automatic send_resp(input logic [31:0] off);
    @(negedge ap_clk);
    response_memory_in.valid = 1'b1;
    response_memory_in.payload.meta.address.offset = off;
    response_memory_in.payload.data = 32'hDEAD_0000 | off;
    @(negedge ap_clk);
    response_memory_in.valid = 1'b0;
  endtask

  // 15 in-range responses (optionally with stray offsets), then the last
  task automatic resp_seq(input string tag, input bit with_oob);
    logic [31:0] oob [5];
    oob = '{32'd40, 32'd40, 32'd40, 32'd15, 32'd32};
    for (int i = 0; i < 15; i++) begin
      send_resp(32'(16 + i));
      if (with_oob && (i % 3 == 0)) send_resp(oob[i/3]);
    end
    if (with_oob) send_resp(32'd40);
    cycles(3);
    chk({tag, "_done_pre"}, 64'(done_out), 64'd0);
    send_resp(32'd31);
    chk({tag, "_done_lat"}, 64'(done_out), 64'd0);
    @(negedge ap_clk);
    chk({tag, "_done"}, 64'(done_out), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    areset = 1'b1;
    start_in = 1'b0;
    base_address_in = '0;
    response_memory_in = '0;
    fifo_in.rd_en = 1'b0;
    cycles(4);
    areset = 1'b0;
    @(negedge ap_clk);
    chk("rst_setup", 64'(fifo_setup_signal), 64'd1);
    chk("rst_done", 64'(done_out), 64'd0);
    chk("rst_valid", 64'(request_memory_out.valid), 64'd0);
    wait_setup("rst");
    chk("rst_empty", 64'(fifo_out.empty), 64'd1);
    chk("rst_noreq", 64'(q.size()), 64'd0);

    // Normal load with downstream always ready
    q.delete();
    fifo_in.rd_en = 1'b1;
    pulse_start(32'h0000_1000);
    wait_reqs(16, 100);
    cycles(10);
    check_burst("t1", 32'h0000_1000);
    if (q.size() > 0)
      chk("t1_route", 64'(q[0].meta.route), 64'h02_01_03_04_05);
    resp_seq("t1", 1'b0);

    // Downstream stalled: FIFO fills to the threshold and holds
    q.delete();
    fifo_in.rd_en = 1'b0;
    pulse_start(32'h0000_2000);
    @(negedge ap_clk);
    chk("t2_done_clr", 64'(done_out), 64'd0);
    cycles(30);
    chk("t2_stall_q", 64'(q.size()), 64'd0);
    chk("t2_prog_full", 64'(fifo_out.prog_full), 64'd1);
    chk("t2_not_full", 64'(fifo_out.full), 64'd0);
    fifo_in.rd_en = 1'b1;
    wait_reqs(16, 100);
    cycles(10);
    check_burst("t2", 32'h0000_2000);
    resp_seq("t2", 1'b1);

    // Extra starts during ISSUE and WAIT_RESP are ignored
    q.delete();
    pulse_start(32'h0000_3000);
    cycles(4);
    pulse_start(32'h0000_9000);
    wait_reqs(16, 100);
    cycles(10);
    pulse_start(32'h0000_A000);
    cycles(30);
    check_burst("t3", 32'h0000_3000);
    resp_seq("t3", 1'b0);

    // Reset in the middle of a burst
    q.delete();
    pulse_start(32'h0000_5000);
    wait_reqs(7, 100);
    chk("t4_pre", 64'(q.size() >= 7), 64'd1);
    areset = 1'b1;
    cycles(3);
    chk("t4_done_rst", 64'(done_out), 64'd0);
    q.delete();
    areset = 1'b0;
    cycles(20);
    chk("t4_no_req", 64'(q.size()), 64'd0);
    chk("t4_done", 64'(done_out), 64'd0);
    chk("t4_empty", 64'(fifo_out.empty), 64'd1);
    wait_setup("t4");
    pulse_start(32'h0000_6000);
    wait_reqs(16, 100);
    cycles(10);
    check_burst("t5", 32'h0000_6000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
